// File: rtl/ising_l1_stream_reader.sv
// Streams num_words sequential L1 reads into a valid/ready word stream through a credit-limited FIFO.
// Optional stall performance counter: define IC_STREAM_PERF_CNT_EN.
module ising_l1_stream_reader #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BANK_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stream_valid_o,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  input  logic                  stream_ready_i,
  output logic [31:0]           stall_cycles_o
);

  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  // A buffer shallower than the bank pipeline could not absorb every in-flight word.
  localparam int unsigned CREDITS = (FIFO_DEPTH > BANK_LATENCY) ? FIFO_DEPTH : BANK_LATENCY + 1;
  localparam int unsigned PTR_W   = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int unsigned SLOTS   = 1 << PTR_W;
  localparam int unsigned OCC_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  issued_d;
  logic [OCC_W-1:0]      outst_q;
  logic [OCC_W-1:0]      outst_d;
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_q [SLOTS];

  logic             active;
  logic [OCC_W:0]   credit_used;
  logic             credit_ok;
  logic             grant;
  logic             rsp_accept;
  logic             push;
  logic             pop;

  assign active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign credit_used = {1'b0, outst_q} + {1'b0, occ_q};
  assign credit_ok   = credit_used < (OCC_W + 1)'(CREDITS);

  // Request only ever falls through a grant or an abort: without a grant the credit sum cannot grow.
  assign mem_req_o  = (state_q == S_ISSUE) && !abort_i && (issued_q != num_q) && credit_ok;
  assign mem_addr_o = addr_q;
  assign grant      = mem_req_o && mem_gnt_i;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign rsp_accept = mem_rvalid_i && (outst_q != '0) && (active || (state_q == S_FLUSH));
  assign push       = rsp_accept && active;
  assign pop        = stream_valid_o && stream_ready_i;

  assign stream_valid_o = (occ_q != '0);
  assign stream_data_o  = fifo_q[rd_ptr_q];
  assign busy_o         = busy_q;
  assign done_o         = done_q;

  always_comb begin
    outst_d = outst_q;
    if (grant && !rsp_accept) begin
      outst_d = outst_q + OCC_W'(1);
    end else if (!grant && rsp_accept) begin
      outst_d = outst_q - OCC_W'(1);
    end
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    issued_d = grant ? issued_q + CNT_WIDTH'(1) : issued_q;
  end

  generate
    for (genvar gi = 0; gi < int'(SLOTS); gi++) begin : g_fifo
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          fifo_q[gi] <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_q[gi] <= mem_rdata_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      outst_q  <= outst_d;
      occ_q    <= occ_d;
      issued_q <= issued_d;
      if (grant) begin
        addr_q <= addr_q + ADDR_WIDTH'(BYTES);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            num_q    <= num_words_i;
            issued_q <= '0;
            addr_q   <= base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
            if (num_words_i != '0) begin
              state_q <= S_ISSUE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            state_q  <= S_FLUSH;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else if (issued_d == num_q) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort_i) begin
            state_q  <= S_FLUSH;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
          end else if ((outst_d == '0) && (occ_d == '0)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        S_FLUSH: begin
          if (outst_d == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IC_STREAM_PERF_CNT_EN
  logic [31:0] stall_q;
  logic        stall_event;

  assign stall_event = (mem_req_o && !mem_gnt_i) || (stream_valid_o && !stream_ready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      stall_q <= '0;
    end else if (stall_event && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: doc/ising_l1_stream_reader.md
# ising_l1_stream_reader

Read-side streaming engine for the Ising core L1 memories (J, H, flip). Given a base address and a word count, it issues sequential single-word reads on one narrow memory port and turns the fixed-latency responses into a valid/ready word stream for the Ising core datapath. A credit-limited response FIFO guarantees that no returned word is dropped when the consumer stalls. One instance sits directly downstream of each L1 memory narrow port.

## Interface
- ADDR_WIDTH, 16: byte address width of the L1 memory.
- DATA_WIDTH, 64: word width; equals the narrow data width.
- BANK_LATENCY, 1: cycles from grant to `mem_rvalid_i`; legal range 1..4.
- FIFO_DEPTH, 4: response buffer depth; power of 2, at least BANK_LATENCY+1.
- CNT_WIDTH, 16: width of the word-count field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start pulse; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first byte address; low log2(DATA_WIDTH/8) bits ignored.
- num_words_i  in  CNT_WIDTH  words to read; sampled with start_i.
- abort_i  in  1  cancel the current transfer.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- mem_req_o  out  1  read request.
- mem_addr_o  out  ADDR_WIDTH  word-aligned read address.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_WIDTH  read data.
- stream_valid_o  out  1  output word valid.
- stream_data_o  out  DATA_WIDTH  output word.
- stream_ready_i  in  1  consumer ready.
- stall_cycles_o  out  32  performance counter (see Configuration).

## Operation
- States and transitions:
  - IDLE to ISSUE on start_i when num_words_i != 0.
  - IDLE to DONE on start_i when num_words_i == 0.
  - ISSUE to DRAIN when the issued count equals num_words.
  - DRAIN to DONE when outstanding == 0 and the FIFO is empty.
  - DONE to IDLE after one cycle; done_o is high during DONE.
  - ISSUE or DRAIN to FLUSH on abort_i.
  - FLUSH to IDLE when outstanding == 0; done_o is not pulsed.
- Credit rule: mem_req_o is asserted in ISSUE only when outstanding + FIFO occupancy < FIFO_DEPTH and issued < num_words.
  - outstanding counts grants whose rvalid has not yet returned.
  - A grant and an rvalid in the same cycle leave outstanding unchanged.
- Once asserted, mem_req_o and mem_addr_o hold stable until mem_gnt_i. The only exception is abort, which may withdraw the request.
- Address behaviour:
  - Starts at base_addr_i with the low bits zeroed.
  - Increments by DATA_WIDTH/8 on each grant.
  - Wraps modulo 2^ADDR_WIDTH; wrap is not an error.
- Every mem_rvalid_i pushes mem_rdata_i into the FIFO, except in FLUSH, where responses are discarded.
- Push and pop in the same cycle leave occupancy unchanged. By construction the FIFO never overflows.
- stream_valid_o equals FIFO not empty. A pop occurs on stream_valid_o && stream_ready_i. Words leave in address order.
- start_i is ignored outside IDLE. abort_i is ignored in IDLE and DONE.
- On entering FLUSH, mem_req_o drops and the FIFO is cleared.

## Timing
- Reset values: state IDLE; busy_o, done_o, mem_req_o, stream_valid_o = 0; mem_addr_o, stream_data_o, stall_cycles_o = 0; all counters 0.
- Start sequence:
  - start_i in cycle 0.
  - busy_o and mem_req_o high from cycle 1.
  - With an immediate grant, rvalid arrives in cycle 1+BANK_LATENCY.
  - stream_valid_o goes high in cycle 2+BANK_LATENCY, because the FIFO output is registered.
- Sustained throughput is one word per cycle when FIFO_DEPTH >= BANK_LATENCY+2 and the consumer is always ready.
- Completion: done_o pulses in the cycle after the last pop; busy_o is low in that same cycle.
- Zero-word start: done_o in cycle 1 and no mem_req_o at any point.
- Reset mid-transfer returns all state to reset values in the next cycle. Late rvalid from the memory after reset is ignored.

## Configuration
- IC_STREAM_PERF_CNT_EN defined:
  - stall_cycles_o is a 32-bit saturating counter, cleared on an accepted start_i.
  - It increments on each cycle where (mem_req_o && !mem_gnt_i) || (stream_valid_o && !stream_ready_i).
- IC_STREAM_PERF_CNT_EN undefined: the counter logic is absent and stall_cycles_o is tied to 0.

## Test plan
- base 0x0100, num 8, gnt and ready always high, BANK_LATENCY 1 -> addresses 0x0100..0x0138 in steps of 8; 8 words in order; first stream_valid_o at cycle 3; done_o at cycle 11.
- num 16, stream_ready_i low for 10 cycles after the first word, FIFO_DEPTH 4 -> at most 4 words in flight, mem_req_o deasserted while credits are exhausted, no word lost or duplicated.
- base 0xFFF0 (ADDR_WIDTH 16), num 4 -> addresses 0xFFF0, 0xFFF8, 0x0000, 0x0008.
- num 0 -> done_o pulse in cycle 1, mem_req_o never asserted.
- abort_i with 2 reads outstanding -> outstanding rvalids discarded, no stream_valid_o after FLUSH, no done_o, return to IDLE; a new start then completes normally.
- IC_STREAM_PERF_CNT_EN defined, gnt withheld 3 cycles and ready low 2 cycles -> stall_cycles_o = 5.
